// File: rtl/isa_pkg.sv
// Shared ISA definitions for the single-cycle core: opcode maps and sequencer states.
// The plain map applies when prep_active=0; the prep map applies when prep_active=1.
package isa_pkg;

    // Plain opcode map
    localparam logic [2:0] OP_PREP = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ANDI = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_RSVD = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Prep opcode map; 110 and 111 are illegal here
    localparam logic [2:0] OP_PMOV = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_SAVE = 3'b100;
    localparam logic [2:0] OP_PSFT = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StMemWait,
        StHalted
    } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: taken branch loads the absolute target, otherwise pc+1.
// The increment wraps modulo 2^PC_W by truncation.
module pc_next_calc #(
    parameter int unsigned PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic            takeBranch,
    input  logic [PC_W-1:0] branchTarget,
    output logic [PC_W-1:0] pcNext
);

    always_comb begin
        pcNext = takeBranch ? branchTarget : pc + 1'b1;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC, paces commit, tracks PREP state,
// resolves BEQ, stalls on data-memory handshakes and stops on HALT.
module pc_sequencer
    import isa_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned OP_LSB  = 6,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch_cond,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               dmem_ack,
    output logic [PC_W-1:0]    pc,
    output logic               commit,
    output logic               prep_active,
    output logic               dmem_req,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   instr_count
);

    seq_state_t        state, stateNext;
    logic [PC_W-1:0]   pcD, pcNext;
    logic              prepD, reqD, doneD;
    logic [CNT_W-1:0]  countD, countInc;
    logic [2:0]        op;
    logic              isMem, isBranch, isHalt;
    logic              unusedInstrBits;

    assign op              = instr[OP_LSB+2:OP_LSB];
    assign unusedInstrBits = ^instr;

    // Illegal opcodes need no decode: they fall through as committing NOPs and the
    // prep update below clears prep_active for the prep-map illegals.
    assign isMem    = prep_active & ((op == OP_LW) | (op == OP_SW));
    assign isBranch = prep_active & (op == OP_BEQ);
    assign isHalt   = !prep_active & (op == OP_HALT);

    assign countInc = (instr_count == {CNT_W{1'b1}}) ? instr_count : instr_count + 1'b1;
    assign busy     = (state == StRun) | (state == StMemWait);

    pc_next_calc #(
        .PC_W (PC_W)
    ) uPcNext (
        .pc           (pc),
        .takeBranch   (isBranch & branch_cond),
        .branchTarget (branch_target),
        .pcNext       (pcNext)
    );

    always_comb begin
        stateNext = state;
        pcD       = pc;
        prepD     = prep_active;
        reqD      = dmem_req;
        doneD     = done;
        countD    = instr_count;
        commit    = 1'b0;
        case (state)
            StIdle: begin
                if (start) begin
                    stateNext = StRun;
                    pcD       = '0;
                    countD    = '0;
                end
            end
            StRun: begin
                if (isMem) begin
                    stateNext = StMemWait;
                    reqD      = 1'b1;
                end else begin
                    commit = 1'b1;
                    countD = countInc;
                    prepD  = prep_active ? (op == OP_PSFT) : (op == OP_PREP);
                    if (isHalt) begin
                        stateNext = StHalted;
                        doneD     = 1'b1;
                    end else begin
                        pcD = pcNext;
                    end
                end
            end
            StMemWait: begin
                if (dmem_ack) begin
                    commit    = 1'b1;
                    stateNext = StRun;
                    reqD      = 1'b0;
                    pcD       = pcNext;
                    prepD     = 1'b0;
                    countD    = countInc;
                end
            end
            StHalted: begin
                if (start) begin
                    stateNext = StRun;
                    pcD       = '0;
                    doneD     = 1'b0;
                    countD    = '0;
                    prepD     = 1'b0;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            pc          <= '0;
            prep_active <= 1'b0;
            dmem_req    <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= stateNext;
            pc          <= pcD;
            prep_active <= prepD;
            dmem_req    <= reqD;
            done        <= doneD;
            instr_count <= countD;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-flow controller for the single-cycle ISA core: owns the PC, paces instruction commit, tracks PREP-prefix state, resolves BEQ, stalls on data-memory LW/SW handshakes, and stops on HALT.
- Sits between the instruction ROM, the control decoder and the data memory.
- Its `commit` strobe gates every architectural write in the core: regfile, prep register and data memory.

Parameters:
- PC_W, 8, PC and branch-target width; instruction memory depth is 2^PC_W.
- OP_LSB, 6, bit position of opcode[0] within `instr`; opcode = instr[OP_LSB+2:OP_LSB].
- INSTR_W, 9, instruction width.
- CNT_W, 16, width of the committed-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  launch program from PC 0 (one-cycle pulse)
- instr  in  INSTR_W  instruction at `pc`, combinational ROM read
- branch_cond  in  1  ALU-zero result for the current instruction
- branch_target  in  PC_W  absolute target, read from the prep register
- dmem_ack  in  1  data memory has completed the request
- pc  out  PC_W  current program counter
- commit  out  1  current instruction retires this cycle
- prep_active  out  1  next decode uses prep-mode opcode map
- dmem_req  out  1  data-memory request, held until ack
- busy  out  1  state is RUN or MEM_WAIT
- done  out  1  program halted
- instr_count  out  CNT_W  retired instructions since start

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALTED. All outputs and registers are registered except `commit`.
- Reset: state=IDLE, pc=0, prep_active=0, dmem_req=0, done=0, instr_count=0. Reset wins over every other input, including mid-MEM_WAIT; an outstanding dmem_req drops the next cycle.
- IDLE: start=1 -> RUN, pc=0, instr_count=0. No other effect.
- Classification uses the current opcode op and prep_active:
  - memory op = prep & (op==010 | op==011)
  - branch = prep & op==001
  - halt = !prep & op==111
  - illegal = (!prep & op==110) | (prep & op[2:1]==11)
- RUN, non-memory, non-halt instruction:
  - commit=1 combinationally.
  - Next edge: pc <= (branch & branch_cond) ? branch_target : pc+1, wrapping modulo 2^PC_W (255+1 -> 0).
  - instr_count increments and saturates at all-ones.
- Illegal opcode: commits as a NOP. pc advances; prep_active is cleared if it was set.
- PREP tracking, on commit only:
  - !prep & op==000 -> prep_active=1.
  - prep & op in {000,001,010,011,100} -> prep_active=0.
  - prep & op==101 (PSFT) -> prep_active stays 1.
- Memory op in RUN: commit=0. Next edge: dmem_req=1, state=MEM_WAIT. Minimum memory-op latency is 2 cycles.
- MEM_WAIT: dmem_req held at 1.
  - dmem_ack=1 in a cycle -> commit=1 that cycle. Next edge: dmem_req=0, pc+1, prep_active=0, count+1, state=RUN.
  - dmem_ack while not in MEM_WAIT is ignored.
- Halt in RUN: commit=1 (counted). Next edge: state=HALTED, done=1, pc unchanged.
- HALTED: done held high. start=1 -> RUN, pc=0, done=0, count=0, prep_active=0.
- start while busy is ignored.
- commit is 0 in IDLE and HALTED.

Decomposition:
- Package isa_pkg holds:
  - opcode localparams, plain and prep maps (OP_PREP=000 … OP_HALT=111; OP_ANDI, OP_BEQ, OP_LW, OP_SW, OP_SAVE, OP_PSFT).
  - seq_state_t enum.
- Both the decoder and this block import isa_pkg.
- One sub-module, pc_next_calc: combinational next-PC mux plus wrap. Everything else stays in one FSM module.

Test Plan:
- Reset then start; ROM = INC, INC, HALT -> commit 3 cycles, pc 0→1→2, done=1 on cycle 4, instr_count=3, pc stays 2.
- ROM[0]=PREP, ROM[1]=BEQ, branch_target=0x20, branch_cond=1 -> prep_active 1 after cycle 1; pc=0x20 after cycle 2; prep_active=0. Repeat with branch_cond=0 -> pc=2.
- PREP, LW with dmem_ack asserted 3 cycles after dmem_req -> dmem_req high for exactly 3 cycles, commit single pulse on the ack cycle, pc 1→2, count=2.
- PREP, PSFT, PSFT, SAVE -> prep_active stays 1 through both PSFTs, clears after SAVE; pc=4.
- pc=0xFF holding INC -> pc wraps to 0x00. Reset asserted mid-MEM_WAIT -> IDLE, dmem_req=0 next cycle, pc=0.
- After HALT, start pulse -> pc=0, done=0, count=0, RUN resumes. start pulses during RUN have no effect.
